useq_io_harness: RTL

Parametrised board-side harness for the useq microsequencer.
- Replaces the ad-hoc reset shift register, 1-bit ticker, and tied-off host FIFO strobes.
- Generates a stretched core reset and a configurable tick bit.
- Synchronises N_IN external inputs and packs them into the core's i_port.
- Bridges a host valid/ready byte stream to the core's read_fifo/write_fifo FIFO strobe interface in both directions.

---
 rtl/useq_io_harness_pkg.sv | 13 +
 rtl/useq_io_harness_if.sv | 18 +
 rtl/useq_io_harness_sync.sv | 17 +
 rtl/useq_io_harness.sv | 109 ++++++++++
 4 files changed

// File: rtl/useq_io_harness_pkg.sv
// useq_harness_pkg: shared types, counter-width helpers and defaults for the useq I/O harness
package useq_harness_pkg;
  localparam int PORT_W_DEF = 8;
  typedef enum logic [1:0] {RX_IDLE, RX_POP, RX_HOLD} rx_state_t;
  // Reset counter must hold the value n itself.
  function automatic int rst_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
  // Divider counts 0..n-1; keep at least one bit so n=1 still elaborates.
  function automatic int div_cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/useq_io_harness_if.sv
// useq_io_harness_if: host byte stream and core FIFO strobe bundle
// master: host/core side driving tx stream, rx_ready and FIFO status
// slave: harness side driving tx_ready, rx stream and FIFO strobes
interface useq_io_harness_if import useq_harness_pkg::*; #(
  parameter int PORT_W = PORT_W_DEF
);
  logic [PORT_W-1:0] tx_data, rx_data, fifo_in, fifo_out;
  logic tx_valid, tx_ready, rx_valid, rx_ready;
  logic write_fifo, fifo_full, read_fifo, fifo_empty;
  modport master (
    output tx_data, tx_valid, rx_ready, fifo_full, fifo_out, fifo_empty,
    input tx_ready, rx_data, rx_valid, write_fifo, fifo_in, read_fifo
  );
  modport slave (
    input tx_data, tx_valid, rx_ready, fifo_full, fifo_out, fifo_empty,
    output tx_ready, rx_data, rx_valid, write_fifo, fifo_in, read_fifo
  );
endinterface

// File: rtl/useq_io_harness_sync.sv
// useq_sync: N-bit multi-flop synchroniser, cleared by rst
// ports: clk, rst, d (async in), q (synchronised out, STAGES cycles later)
module useq_sync import useq_harness_pkg::*; #(
  parameter int N = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);
  logic [STAGES-1:0][N-1:0] s;
  always_ff @(posedge clk)
    if (rst) s <= '0;
    else s <= {s[STAGES-2:0], d};
  assign q = s[STAGES-1];
endmodule

// File: rtl/useq_io_harness.sv
// useq_io_harness: board-side reset stretcher, ticker, input sync and FIFO bridge for useq
// ports: clk, rst (sync, active high), ext_in (async), core_rst_n, i_port = {0, ext_sync, tick},
//        bus (slave side of useq_io_harness_if: tx/rx host stream and core FIFO strobes)
// optional: USEQ_HARNESS_EDGE_EN adds in_rise, a one-cycle pulse per rising ext_sync bit
module useq_io_harness import useq_harness_pkg::*; #(
  parameter int RST_CYCLES = 8,
  parameter int TICK_DIV = 2,
  parameter int N_IN = 6,
  parameter int SYNC_STAGES = 2,
  parameter int PORT_W = PORT_W_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [(N_IN > 0 ? N_IN : 1)-1:0] ext_in,
  output logic                            core_rst_n,
  output logic [PORT_W-1:0]               i_port,
  useq_io_harness_if.slave                bus
`ifdef USEQ_HARNESS_EDGE_EN
  ,
  output logic [(N_IN > 0 ? N_IN : 1)-1:0] in_rise
`endif
);
  localparam int IN_W = N_IN > 0 ? N_IN : 1;
  localparam int RW = rst_cnt_w(RST_CYCLES);
  localparam int DW = div_cnt_w(TICK_DIV);
  logic [RW-1:0] rst_cnt;
  logic [DW-1:0] div;
  logic tick;
  logic [IN_W-1:0] ext_sync;
  logic tx_hs;
  rx_state_t rx_state;
  useq_sync #(.N(IN_W), .STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(rst),
    .d(ext_in),
    .q(ext_sync)
  );
  // Counter freezes once the core is released.
  always_ff @(posedge clk)
    if (rst) begin
      rst_cnt <= '0;
      core_rst_n <= 1'b0;
    end else if (!core_rst_n) begin
      rst_cnt <= rst_cnt + 1'b1;
      core_rst_n <= rst_cnt == RW'(RST_CYCLES - 1);
    end
  always_ff @(posedge clk)
    if (rst || !core_rst_n) begin
      div <= '0;
      tick <= 1'b0;
    end else if (div == DW'(TICK_DIV - 1)) begin
      div <= '0;
      tick <= !tick;
    end else div <= div + 1'b1;
  always_comb begin
    i_port = '0;
    i_port[0] = tick;
    for (int i = 0; i < N_IN; i++) i_port[i+1] = ext_sync[i];
  end
  // Blocking on write_fifo limits tx to one byte per two cycles so fifo_full is current.
  assign bus.tx_ready = !rst && core_rst_n && !bus.fifo_full && !bus.write_fifo;
  assign tx_hs = bus.tx_valid && bus.tx_ready;
  always_ff @(posedge clk)
    if (rst) begin
      bus.write_fifo <= 1'b0;
      bus.fifo_in <= '0;
    end else begin
      bus.write_fifo <= tx_hs;
      if (tx_hs) bus.fifo_in <= bus.tx_data;
    end
  // fifo_out is sampled in RX_POP, the cycle the pop strobe is presented to the core.
  always_ff @(posedge clk)
    if (rst) begin
      rx_state <= RX_IDLE;
      bus.read_fifo <= 1'b0;
      bus.rx_valid <= 1'b0;
      bus.rx_data <= '0;
    end else
      case (rx_state)
        RX_IDLE:
          if (core_rst_n && !bus.fifo_empty) begin
            bus.read_fifo <= 1'b1;
            rx_state <= RX_POP;
          end
        RX_POP: begin
          bus.read_fifo <= 1'b0;
          bus.rx_data <= bus.fifo_out;
          bus.rx_valid <= 1'b1;
          rx_state <= RX_HOLD;
        end
        RX_HOLD:
          if (bus.rx_ready) begin
            bus.rx_valid <= 1'b0;
            rx_state <= RX_IDLE;
          end
        default: rx_state <= RX_IDLE;
      endcase
`ifdef USEQ_HARNESS_EDGE_EN
  logic [IN_W-1:0] sync_q;
  always_ff @(posedge clk)
    if (rst) begin
      sync_q <= '0;
      in_rise <= '0;
    end else begin
      sync_q <= ext_sync;
      in_rise <= core_rst_n ? ext_sync & ~sync_q : '0;
    end
`endif
endmodule
